// File: rtl/symbol_sequencer_if.sv
// rtl/symbol_sequencer_if.sv - control and display bundle between the switch front end and the symbol sequencer
interface symbol_sequencer_if #(
    parameter int NBITS_SYM = 6,
    parameter int NBITS_IDX = 4
);
    logic                 wr_en;
    logic [NBITS_SYM-1:0] wr_data;
    logic                 clr;
    logic                 start;
    logic                 pause;
    logic [NBITS_SYM-1:0] sym_code;
    logic                 sym_valid;
    logic [NBITS_IDX-1:0] index;
    logic [NBITS_IDX:0]   length;
    logic                 full;
    logic                 busy;

    modport master (
        output wr_en, wr_data, clr, start, pause,
        input  sym_code, sym_valid, index, length, full, busy
    );

    modport slave (
        input  wr_en, wr_data, clr, start, pause,
        output sym_code, sym_valid, index, length, full, busy
    );
endinterface

// File: rtl/symbol_sequencer.sv
// rtl/symbol_sequencer.sv - stores a short symbol message and replays it to the seven-segment decoder
module symbol_sequencer #(
    parameter int NBITS_SYM      = 6,
    parameter int DEPTH          = 16,
    parameter int NBITS_IDX      = 4,
    parameter int TICKS_PER_STEP = 2
) (
    input  logic                  clk_2,
    input  logic                  reset,
    symbol_sequencer_if.slave     bus
);
    localparam int NBITS_CNT = (TICKS_PER_STEP > 1) ? $clog2(TICKS_PER_STEP) : 1;
    localparam logic [NBITS_CNT-1:0] CNT_LAST = NBITS_CNT'(TICKS_PER_STEP - 1);
    localparam logic [NBITS_IDX:0]   LEN_FULL = (NBITS_IDX + 1)'(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PLAY,
        ST_PAUSE
    } state_t;

    state_t               state_q, state_d;
    logic [NBITS_CNT-1:0] cnt_q, cnt_d;
    logic [NBITS_IDX-1:0] idx_q, idx_d;
    logic [NBITS_IDX:0]   len_q, len_d;
    logic [NBITS_SYM-1:0] code_q, code_d;
    logic                 valid_q;
    logic                 full_q;
    logic                 busy_q;
    logic                 mem_we;
    logic [NBITS_IDX-1:0] last_idx;
    logic [NBITS_SYM-1:0] mem [DEPTH];

    assign last_idx = NBITS_IDX'(len_q - 1'b1);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        len_d   = len_q;
        code_d  = code_q;
        mem_we  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // start is judged on the pre-edge length and swallows any write/clear on the same edge
                if (bus.start) begin
                    if (len_q != '0) begin
                        state_d = ST_PLAY;
                        cnt_d   = '0;
                        idx_d   = '0;
                        code_d  = mem[0];
                    end
                end else if (bus.clr) begin
                    len_d = '0;
                end else if (bus.wr_en && !full_q) begin
                    mem_we = 1'b1;
                    len_d  = len_q + 1'b1;
                end
            end
            ST_PLAY, ST_PAUSE: begin
                if (bus.start) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    idx_d   = '0;
                    code_d  = '0;
                end else if (bus.pause) begin
                    state_d = ST_PAUSE;
                end else begin
                    // leaving PAUSE counts on the same edge, so a pause of N cycles stretches the hold by exactly N
                    state_d = ST_PLAY;
                    if (cnt_q == CNT_LAST) begin
                        cnt_d  = '0;
                        idx_d  = (idx_q == last_idx) ? '0 : idx_q + 1'b1;
                        code_d = mem[idx_d];
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
                idx_d   = '0;
                code_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk_2) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            len_q   <= '0;
            code_q  <= '0;
            valid_q <= 1'b0;
            full_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            len_q   <= len_d;
            code_q  <= code_d;
            valid_q <= (state_d != ST_IDLE);
            full_q  <= (len_d == LEN_FULL);
            busy_q  <= (state_d != ST_IDLE);
        end
    end

    always_ff @(posedge clk_2) begin
        if (!reset && mem_we) begin
            mem[len_q[NBITS_IDX-1:0]] <= bus.wr_data;
        end
    end

    assign bus.sym_code  = code_q;
    assign bus.sym_valid = valid_q;
    assign bus.index     = idx_q;
    assign bus.length    = len_q;
    assign bus.full      = full_q;
    assign bus.busy      = busy_q;
endmodule
